// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU write-back path.
//   REG_IDX_W / NREGS / DATA_W : register-file geometry
//   wb_entry                   : one buffered load return {idx, data, live}
//   idx_onehot()               : register index -> one-hot register mask
package cpu_pkg;
  localparam int REG_IDX_W = 4;
  localparam int NREGS     = 16;
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
    logic                 live;
  } wb_entry;

  function automatic logic [NREGS-1:0] idx_onehot(input logic [REG_IDX_W-1:0] idx);
    return NREGS'(1) << idx;
  endfunction
endpackage

// File: rtl/cpu_wb_arbiter_if.sv
// Write-back bus bundle: execute result, load-return handshake,
// register-file write port and the per-register pending mask.
//   slave  : the arbiter side (consumes ex/ld, drives rf/pending/ready)
//   master : the pipeline / bench side
interface cpu_wb_arbiter_if;
  import cpu_pkg::*;
  logic                 ex_we_i;
  logic [REG_IDX_W-1:0] ex_idx_i;
  logic [DATA_W-1:0]    ex_data_i;
  logic                 ld_valid_i;
  logic [REG_IDX_W-1:0] ld_idx_i;
  logic [DATA_W-1:0]    ld_data_i;
  logic                 ld_ready_o;
  logic                 rf_we_o;
  logic [REG_IDX_W-1:0] rf_idx_o;
  logic [DATA_W-1:0]    rf_data_o;
  logic [NREGS-1:0]     pending_o;

  modport slave (
    input  ex_we_i, ex_idx_i, ex_data_i, ld_valid_i, ld_idx_i, ld_data_i,
    output ld_ready_o, rf_we_o, rf_idx_o, rf_data_o, pending_o
  );
  modport master (
    output ex_we_i, ex_idx_i, ex_data_i, ld_valid_i, ld_idx_i, ld_data_i,
    input  ld_ready_o, rf_we_o, rf_idx_o, rf_data_o, pending_o
  );
endinterface

// File: rtl/cpu_wb_fifo.sv
// In-order circular buffer for load returns that lost write-back arbitration.
// Ports:
//   clk_i, rst_i          clock, async active-low reset
//   push_i, push_ent_i    append entry at tail (entry may arrive already dead)
//   pop_i                 drop head entry
//   kill_en_i, kill_idx_i mark every occupied entry targeting kill_idx_i dead
//   head_o, empty_o, full_o
//   nxt_live_o, nxt_idx_o per-slot next-state liveness/index (for pending mask)
//   kill_hits_o           live entries killed this cycle (CPU_WB_ARBITER_STATS_EN only)
module cpu_wb_fifo
  import cpu_pkg::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                push_i,
  input  wb_entry                             push_ent_i,
  input  logic                                pop_i,
  input  logic                                kill_en_i,
  input  logic [REG_IDX_W-1:0]                kill_idx_i,
  output wb_entry                             head_o,
  output logic                                empty_o,
  output logic                                full_o,
  output logic [LD_DEPTH-1:0]                 nxt_live_o,
  output logic [LD_DEPTH-1:0][REG_IDX_W-1:0]  nxt_idx_o
`ifdef CPU_WB_ARBITER_STATS_EN
  ,
  output logic [$clog2(LD_DEPTH):0]           kill_hits_o
`endif
);
  localparam int PW = $clog2(LD_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]                     rd_q, wr_q;
  logic [CW-1:0]                     cnt_q;
  logic [LD_DEPTH-1:0]               occ_q, occ_d, live_q, live_d;
  logic [LD_DEPTH-1:0]               sel_wr, sel_rd, kill_hit;
  logic [LD_DEPTH-1:0][REG_IDX_W-1:0] idx_q;
  logic [LD_DEPTH-1:0][DATA_W-1:0]    data_q;

  for (genvar g = 0; g < LD_DEPTH; g++) begin : g_slot
    assign sel_wr[g]   = push_i && (wr_q == PW'(g));
    assign sel_rd[g]   = pop_i  && (rd_q == PW'(g));
    // Only live entries count as hits so a re-kill of a dead slot is a no-op.
    assign kill_hit[g] = kill_en_i && occ_q[g] && live_q[g] && (idx_q[g] == kill_idx_i);
    // Push never lands on the popped slot: that would need count==LD_DEPTH,
    // where the arbiter refuses loads.
    assign occ_d[g]     = sel_wr[g] | (occ_q[g] & ~sel_rd[g]);
    assign live_d[g]    = sel_wr[g] ? push_ent_i.live : (live_q[g] & ~kill_hit[g]);
    assign nxt_idx_o[g] = sel_wr[g] ? push_ent_i.idx : idx_q[g];
  end

  assign nxt_live_o = occ_d & live_d;
  assign head_o     = '{idx: idx_q[rd_q], data: data_q[rd_q], live: live_q[rd_q]};
  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CW'(LD_DEPTH));
`ifdef CPU_WB_ARBITER_STATS_EN
  assign kill_hits_o = CW'($countones(kill_hit));
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      occ_q  <= '0;
      live_q <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      rd_q   <= rd_q + PW'(pop_i);
      wr_q   <= wr_q + PW'(push_i);
      cnt_q  <= cnt_q + CW'(push_i) - CW'(pop_i);
      occ_q  <= occ_d;
      live_q <= live_d;
      for (int i = 0; i < LD_DEPTH; i++) begin
        if (sel_wr[i]) begin
          idx_q[i]  <= push_ent_i.idx;
          data_q[i] <= push_ent_i.data;
        end
      end
    end
  end
endmodule

// File: rtl/cpu_wb_arbiter.sv
// Register-file write-port arbiter.
// Execute results always win; load returns that lose wait in cpu_wb_fifo.
// An execute write kills older buffered loads to the same register (WAW),
// and pending_o flags registers still owed a live buffered load.
// Ports:
//   clk_i, rst_i  clock, async active-low reset
//   bus           cpu_wb_arbiter_if.slave (ex/ld inputs, ld_ready, rf write, pending)
//   conflict_cnt_o, kill_cnt_o  saturating stats (only with CPU_WB_ARBITER_STATS_EN)
module cpu_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int LD_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cpu_wb_arbiter_if.slave       bus
`ifdef CPU_WB_ARBITER_STATS_EN
  ,
  output logic [31:0]           conflict_cnt_o,
  output logic [31:0]           kill_cnt_o
`endif
);
  wb_entry                            head, push_ent;
  logic                               empty, full;
  logic                               ld_acc, bypass, pop, push;
  logic                               wr_en;
  logic [REG_IDX_W-1:0]               wr_idx;
  logic [DATA_W-1:0]                  wr_data;
  logic [LD_DEPTH-1:0]                nxt_live;
  logic [LD_DEPTH-1:0][REG_IDX_W-1:0] nxt_idx;
  logic [NREGS-1:0]                   pending_d;
`ifdef CPU_WB_ARBITER_STATS_EN
  logic [$clog2(LD_DEPTH):0]          kill_hits;
`endif

  // Ready depends on registered occupancy only.
  assign bus.ld_ready_o = !full;
  assign ld_acc         = bus.ld_valid_i && bus.ld_ready_o;
  assign push           = ld_acc && !bypass;
  // The execute instruction is younger than a same-cycle load to the same
  // register, so that load enters the buffer already dead.
  assign push_ent = '{idx:  bus.ld_idx_i,
                      data: bus.ld_data_i,
                      live: !(bus.ex_we_i && bus.ld_idx_i == bus.ex_idx_i)};

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = bus.ex_idx_i;
    wr_data = bus.ex_data_i;
    pop     = 1'b0;
    bypass  = 1'b0;
    if (bus.ex_we_i) begin
      wr_en = 1'b1;
    end else if (!empty) begin
      pop = 1'b1;            // dead head is popped without a write
      if (head.live) begin
        wr_en   = 1'b1;
        wr_idx  = head.idx;
        wr_data = head.data;
      end
    end else if (ld_acc) begin
      bypass  = 1'b1;
      wr_en   = 1'b1;
      wr_idx  = bus.ld_idx_i;
      wr_data = bus.ld_data_i;
    end
  end

  cpu_wb_fifo #(.LD_DEPTH(LD_DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_ent_i (push_ent),
    .pop_i      (pop),
    .kill_en_i  (bus.ex_we_i),
    .kill_idx_i (bus.ex_idx_i),
    .head_o     (head),
    .empty_o    (empty),
    .full_o     (full),
    .nxt_live_o (nxt_live),
    .nxt_idx_o  (nxt_idx)
`ifdef CPU_WB_ARBITER_STATS_EN
    ,
    .kill_hits_o(kill_hits)
`endif
  );

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < LD_DEPTH; i++)
      if (nxt_live[i]) pending_d |= idx_onehot(nxt_idx[i]);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.rf_we_o   <= 1'b0;
      bus.rf_idx_o  <= '0;
      bus.rf_data_o <= '0;
      bus.pending_o <= '0;
    end else begin
      bus.rf_we_o   <= wr_en;
      bus.pending_o <= pending_d;
      if (wr_en) begin
        bus.rf_idx_o  <= wr_idx;
        bus.rf_data_o <= wr_data;
      end
    end
  end

`ifdef CPU_WB_ARBITER_STATS_EN
  logic        conflict;
  logic [32:0] kill_sum;
  // A load is held back by execute whenever execute writes while a load is
  // either waiting in the buffer or being offered.
  assign conflict = bus.ex_we_i && (!empty || bus.ld_valid_i);
  assign kill_sum = {1'b0, kill_cnt_o} + 33'(kill_hits) + 33'(push && !push_ent.live);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      conflict_cnt_o <= '0;
      kill_cnt_o     <= '0;
    end else begin
      if (conflict && conflict_cnt_o != '1) conflict_cnt_o <= conflict_cnt_o + 32'd1;
      kill_cnt_o <= kill_sum[32] ? '1 : kill_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_cpu_wb_arbiter.sv
module tb_cpu_wb_arbiter;
  import cpu_pkg::*;
  localparam int LD_DEPTH = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  cpu_wb_arbiter_if bus();
`ifdef CPU_WB_ARBITER_STATS_EN
  logic [31:0] conflict_cnt_o, kill_cnt_o;
`endif

  cpu_wb_arbiter #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
`ifdef CPU_WB_ARBITER_STATS_EN
    ,
    .conflict_cnt_o(conflict_cnt_o),
    .kill_cnt_o    (kill_cnt_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the buffer is a plain queue of pending loads.
  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    bit          live;
  } m_ent_t;
  m_ent_t      mq[$];
  bit          m_we, m_ready, obs_ready;
  logic [3:0]  m_idx;
  logic [31:0] m_data;
  logic [15:0] m_pend;
  longint      m_conf, m_kill;

  function automatic void model_step(input bit exwe, input logic [3:0] exi, input logic [31:0] exd,
                                     input bit ldv, input logic [3:0] ldi, input logic [31:0] ldd);
    bit acc;
    m_ent_t e;
    m_ready = (mq.size() != LD_DEPTH);
    acc     = ldv && m_ready;
    if (exwe && (mq.size() > 0 || ldv)) m_conf++;
    m_we = 0;
    if (exwe) begin
      foreach (mq[i]) if (mq[i].live && mq[i].idx == exi) begin mq[i].live = 0; m_kill++; end
      m_we = 1; m_idx = exi; m_data = exd;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live) begin m_we = 1; m_idx = e.idx; m_data = e.data; end
    end else if (acc) begin
      m_we = 1; m_idx = ldi; m_data = ldd; acc = 0;
    end
    if (acc) begin
      e.idx = ldi; e.data = ldd; e.live = !(exwe && ldi == exi);
      if (!e.live) m_kill++;
      mq.push_back(e);
    end
    m_pend = '0;
    foreach (mq[i]) if (mq[i].live) m_pend[mq[i].idx] = 1'b1;
  endfunction

  // Apply one cycle of inputs, step the model, and land just after the edge.
  task automatic drive(input bit exwe, input logic [3:0] exi, input logic [31:0] exd,
                       input bit ldv, input logic [3:0] ldi, input logic [31:0] ldd);
    bus.ex_we_i = exwe; bus.ex_idx_i = exi; bus.ex_data_i = exd;
    bus.ld_valid_i = ldv; bus.ld_idx_i = ldi; bus.ld_data_i = ldd;
    #1;
    obs_ready = bus.ld_ready_o;
    model_step(exwe, exi, exd, ldv, ldi, ldd);
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    drive(0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
  endtask

  task automatic test_reset();
    bus.ex_we_i = 0; bus.ex_idx_i = 0; bus.ex_data_i = 0;
    bus.ld_valid_i = 0; bus.ld_idx_i = 0; bus.ld_data_i = 0;
    rst_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++; if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", bus.rf_we_o); end
    n_cmp++; if (bus.rf_idx_o !== 4'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", bus.rf_idx_o); end
    n_cmp++; if (bus.rf_data_o !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.rf_data_o); end
    n_cmp++; if (bus.pending_o !== 16'd0) begin n_bad++; $display("FAIL reset_pend: got %h want 0", bus.pending_o); end
    n_cmp++; if (bus.ld_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.ld_ready_o); end
`ifdef CPU_WB_ARBITER_STATS_EN
    n_cmp++; if (conflict_cnt_o !== 32'd0 || kill_cnt_o !== 32'd0) begin n_bad++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", conflict_cnt_o, kill_cnt_o); end
`endif
    rst_i = 1;
    mq.delete(); m_conf = 0; m_kill = 0;
  endtask

  task automatic test_bypass();
    drive(0, 4'd0, 32'd0, 1, 4'd3, 32'h12345678);
    n_cmp++; if (obs_ready !== 1'b1) begin n_bad++; $display("FAIL byp_ready: got %b want 1", obs_ready); end
    n_cmp++; if (bus.rf_we_o !== 1'b1 || bus.rf_idx_o !== 4'd3 || bus.rf_data_o !== 32'h12345678) begin n_bad++;
      $display("FAIL byp_write: got we=%b r%0d %h want we=1 r3 12345678", bus.rf_we_o, bus.rf_idx_o, bus.rf_data_o); end
    n_cmp++; if (bus.pending_o !== 16'h0) begin n_bad++; $display("FAIL byp_pend: got %h want 0000", bus.pending_o); end
    idle();
    n_cmp++; if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL byp_after: got we=%b want 0", bus.rf_we_o); end
  endtask

  task automatic test_priority();
    logic [3:0]  ei[6]  = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0};
    bit          ew[6]  = '{1, 1, 1, 0, 0, 0};
    bit          lv[6]  = '{1, 1, 0, 0, 0, 0};
    logic [3:0]  li[6]  = '{4'd4, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    bit          xwe[6] = '{1, 1, 1, 1, 1, 0};
    logic [3:0]  xi[6]  = '{4'd1, 4'd1, 4'd1, 4'd4, 4'd5, 4'd0};
    logic [31:0] xd[6]  = '{32'h11, 32'h12, 32'h13, 32'h44, 32'h55, 32'h0};
    logic [15:0] xp[6]  = '{16'h0010, 16'h0030, 16'h0030, 16'h0020, 16'h0000, 16'h0000};
    bit          xr[6]  = '{1, 1, 0, 0, 1, 1};
    logic [31:0] c0;
    c0 = 0;
`ifdef CPU_WB_ARBITER_STATS_EN
    c0 = conflict_cnt_o;
`endif
    for (int i = 0; i < 6; i++) begin
      drive(ew[i], ei[i], 32'h11 + 32'(i), lv[i], li[i], (li[i] == 4'd4) ? 32'h44 : 32'h55);
      n_cmp++; if (obs_ready !== xr[i]) begin n_bad++; $display("FAIL prio_ready[%0d]: got %b want %b", i, obs_ready, xr[i]); end
      n_cmp++; if (bus.rf_we_o !== xwe[i]) begin n_bad++; $display("FAIL prio_we[%0d]: got %b want %b", i, bus.rf_we_o, xwe[i]); end
      if (xwe[i]) begin
        n_cmp++; if (bus.rf_idx_o !== xi[i] || bus.rf_data_o !== xd[i]) begin n_bad++;
          $display("FAIL prio_wr[%0d]: got r%0d %h want r%0d %h", i, bus.rf_idx_o, bus.rf_data_o, xi[i], xd[i]); end
      end
      n_cmp++; if (bus.pending_o !== xp[i]) begin n_bad++; $display("FAIL prio_pend[%0d]: got %h want %h", i, bus.pending_o, xp[i]); end
    end
`ifdef CPU_WB_ARBITER_STATS_EN
    n_cmp++; if (conflict_cnt_o - c0 !== 32'd3) begin n_bad++; $display("FAIL prio_conflicts: got %0d want 3", conflict_cnt_o - c0); end
`endif
  endtask

  task automatic test_waw_kill();
    logic [31:0] k0;
    k0 = 0;
    drive(1, 4'd0, 32'h5, 1, 4'd7, 32'hAAAA);
    n_cmp++; if (bus.pending_o !== 16'h0080) begin n_bad++; $display("FAIL waw_pend_set: got %h want 0080", bus.pending_o); end
`ifdef CPU_WB_ARBITER_STATS_EN
    k0 = kill_cnt_o;
`endif
    drive(1, 4'd7, 32'hBBBB, 0, 4'd0, 32'd0);
    n_cmp++; if (bus.rf_we_o !== 1'b1 || bus.rf_idx_o !== 4'd7 || bus.rf_data_o !== 32'hBBBB) begin n_bad++;
      $display("FAIL waw_ex: got we=%b r%0d %h want we=1 r7 0000bbbb", bus.rf_we_o, bus.rf_idx_o, bus.rf_data_o); end
    n_cmp++; if (bus.pending_o !== 16'h0) begin n_bad++; $display("FAIL waw_pend_clr: got %h want 0000", bus.pending_o); end
    for (int i = 0; i < 2; i++) begin
      idle();
      n_cmp++; if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL waw_dead[%0d]: got we=%b r%0d %h want we=0", i, bus.rf_we_o, bus.rf_idx_o, bus.rf_data_o); end
    end
`ifdef CPU_WB_ARBITER_STATS_EN
    n_cmp++; if (kill_cnt_o - k0 !== 32'd1) begin n_bad++; $display("FAIL waw_kills: got %0d want 1", kill_cnt_o - k0); end
`endif
  endtask

  task automatic test_same_cycle_kill();
    drive(1, 4'd2, 32'hE2, 1, 4'd2, 32'h12);
    n_cmp++; if (bus.rf_we_o !== 1'b1 || bus.rf_idx_o !== 4'd2 || bus.rf_data_o !== 32'hE2) begin n_bad++;
      $display("FAIL same_ex: got we=%b r%0d %h want we=1 r2 000000e2", bus.rf_we_o, bus.rf_idx_o, bus.rf_data_o); end
    n_cmp++; if (bus.pending_o !== 16'h0) begin n_bad++; $display("FAIL same_pend: got %h want 0000", bus.pending_o); end
    idle();
    n_cmp++; if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL same_dead_pop: got we=%b data %h want we=0", bus.rf_we_o, bus.rf_data_o); end
    idle();
    n_cmp++; if (obs_ready !== 1'b1 || bus.rf_we_o !== 1'b0) begin n_bad++;
      $display("FAIL same_drained: got ready=%b we=%b want ready=1 we=0", obs_ready, bus.rf_we_o); end
  endtask

  task automatic test_reset_mid();
    drive(1, 4'd1, 32'h21, 1, 4'd8, 32'h88);
    drive(1, 4'd1, 32'h22, 1, 4'd9, 32'h99);
    n_cmp++; if (bus.pending_o !== 16'h0300) begin n_bad++; $display("FAIL rmid_pend_pre: got %h want 0300", bus.pending_o); end
    bus.ex_we_i = 0; bus.ld_valid_i = 0;
    rst_i = 0;
    #1;
    n_cmp++; if (bus.rf_we_o !== 1'b0 || bus.pending_o !== 16'h0 || bus.ld_ready_o !== 1'b1) begin n_bad++;
      $display("FAIL rmid_async: got we=%b pend=%h ready=%b want 0/0000/1", bus.rf_we_o, bus.pending_o, bus.ld_ready_o); end
    @(posedge clk_i); #1;
    n_cmp++; if (bus.rf_we_o !== 1'b0 || bus.pending_o !== 16'h0 || bus.ld_ready_o !== 1'b1) begin n_bad++;
      $display("FAIL rmid_edge: got we=%b pend=%h ready=%b want 0/0000/1", bus.rf_we_o, bus.pending_o, bus.ld_ready_o); end
    rst_i = 1;
    mq.delete(); m_conf = 0; m_kill = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      n_cmp++; if (bus.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL rmid_nowrite[%0d]: got we=%b r%0d want 0", i, bus.rf_we_o, bus.rf_idx_o); end
    end
  endtask

  task automatic test_random();
    bit          exwe, ldv;
    logic [3:0]  exi, ldi;
    logic [31:0] exd, ldd;
    for (int c = 0; c < 400; c++) begin
      exwe = ($urandom_range(0, 99) < 40);
      ldv  = ($urandom_range(0, 99) < 55);
      exi  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      ldi  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      exd  = $urandom;
      ldd  = $urandom;
      drive(exwe, exi, exd, ldv, ldi, ldd);
      n_cmp++; if (obs_ready !== m_ready) begin n_bad++; $display("FAIL rnd_ready@%0d: got %b want %b", c, obs_ready, m_ready); end
      n_cmp++; if (bus.rf_we_o !== m_we) begin n_bad++; $display("FAIL rnd_we@%0d: got %b want %b", c, bus.rf_we_o, m_we); end
      if (m_we) begin
        n_cmp++; if (bus.rf_idx_o !== m_idx || bus.rf_data_o !== m_data) begin n_bad++;
          $display("FAIL rnd_wr@%0d: got r%0d %h want r%0d %h", c, bus.rf_idx_o, bus.rf_data_o, m_idx, m_data); end
      end
      n_cmp++; if (bus.pending_o !== m_pend) begin n_bad++; $display("FAIL rnd_pend@%0d: got %h want %h", c, bus.pending_o, m_pend); end
    end
`ifdef CPU_WB_ARBITER_STATS_EN
    n_cmp++; if (conflict_cnt_o !== 32'(m_conf)) begin n_bad++; $display("FAIL rnd_conflicts: got %0d want %0d", conflict_cnt_o, m_conf); end
    n_cmp++; if (kill_cnt_o !== 32'(m_kill)) begin n_bad++; $display("FAIL rnd_kills: got %0d want %0d", kill_cnt_o, m_kill); end
`endif
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_priority();
    test_waw_kill();
    test_same_cycle_kill();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
